multicycle_control: RTL and testbench

Moore-style sequencing FSM for the multi-cycle MIPS datapath. It fetches, decodes and executes one instruction over 3–5 clock cycles. It drives every mux select, write enable and ALU operation code of the shared-memory, single-ALU datapath, and resolves branches from the ALU Zero flag. It replaces the single-cycle opcode decoder when the core is built in multi-cycle form.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control_if.sv | 47 ++++
 rtl/multicycle_control_ctrl_output_decode.sv | 90 +++++++++
 rtl/multicycle_control.sv | 84 ++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU
// operation codes, mux select codes, FSM state enum and the control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_J)    || (op == OP_JAL)  ||
               (op == OP_BEQ) || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_ANDI)|| (op == OP_ORI)  || (op == OP_LW)   ||
               (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. The MemReady handshake exists only when
// MEM_READY_EN is defined.
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
`ifdef MEM_READY_EN
    logic       MemReady;
`endif
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALUOp;
    logic       InstrDone;
    logic       IllegalOp;

`ifdef MEM_READY_EN
    modport master (
        input  OP, Zero, MemReady,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp
    );
    modport slave (
        output OP, Zero, MemReady,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp
    );
`else
    modport master (
        input  OP, Zero,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp
    );
    modport slave (
        output OP, Zero,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp
    );
`endif
endinterface

// File: rtl/multicycle_control_ctrl_output_decode.sv
// ctrl_output_decode: Moore decode of FSM state (plus latched opcode and Zero)
// into the datapath control word. en=0 forces the whole word to zero.
import mips_ctrl_pkg::*;

module ctrl_output_decode (
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] op_q,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       en,
    output ctrl_t      ctrl
);

    // Per-state control word; memory-facing strobes in FETCH/MEM_WR qualified by mem_ready
    always_comb begin
        ctrl = '0;
        if (en) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_en     = mem_ready;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                end
                DECODE: begin
                    ctrl.alu_src_b  = SRCB_BRANCH;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.illegal_op = !is_supported(op);
                end
                MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEM_WB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                MEM_WR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_RTYPE;
                end
                R_WB: begin
                    ctrl.reg_dst    = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    if (op_q == OP_ANDI)     ctrl.alu_op = ALU_AND;
                    else if (op_q == OP_ORI) ctrl.alu_op = ALU_OR;
                    else                     ctrl.alu_op = ALU_ADD;
                end
                I_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a  = 1'b1;
                    ctrl.alu_op     = ALU_SUB;
                    ctrl.pc_source  = PCSRC_ALUOUT;
                    ctrl.instr_done = 1'b1;
                    ctrl.pc_en      = ((op_q == OP_BEQ) && zero) ||
                                      ((op_q == OP_BNE) && !zero);
                end
                JUMP: begin
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.pc_en      = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multi-cycle MIPS datapath.
// Optional macro MEM_READY_EN adds a MemReady stall on FETCH/MEM_RD/MEM_WR.
import mips_ctrl_pkg::*;

module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t     state;
    state_t     state_next;
    logic [5:0] op_q;
    logic       mem_ready;
    ctrl_t      ctrl;

`ifdef MEM_READY_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // State and opcode registers; opcode captured as the FSM leaves DECODE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) op_q <= bus.OP;
        end
    end

    // Next-state logic; DECODE dispatches on the live opcode it is latching
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (bus.OP)
                    OP_LW, OP_SW:             state_next = MEM_ADDR;
                    OP_R:                     state_next = R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = I_EXEC;
                    OP_BEQ, OP_BNE:           state_next = BRANCH;
                    OP_J, OP_JAL:             state_next = JUMP;
                    default:                  state_next = FETCH;
                endcase
            end
            MEM_ADDR: state_next = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_next = MEM_WB;
            MEM_WR:   if (mem_ready) state_next = FETCH;
            R_EXEC:   state_next = R_WB;
            I_EXEC:   state_next = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state     (state),
        .op        (bus.OP),
        .op_q      (op_q),
        .zero      (bus.Zero),
        .mem_ready (mem_ready),
        .en        (reset),
        .ctrl      (ctrl)
    );

    assign bus.PCEn      = ctrl.pc_en;
    assign bus.IorD      = ctrl.iord;
    assign bus.MemRead   = ctrl.mem_read;
    assign bus.MemWrite  = ctrl.mem_write;
    assign bus.IRWrite   = ctrl.ir_write;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.MemtoReg  = ctrl.mem_to_reg;
    assign bus.RegWrite  = ctrl.reg_write;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.PCSource  = ctrl.pc_source;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.InstrDone = ctrl.instr_done;
    assign bus.IllegalOp = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected
// per-cycle control words of each instruction, a monitor compares them at
// the falling edge. Covers MEM_READY_EN stalls when that macro is defined.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic stim_done = 1'b0;
    logic mon_done = 1'b0;

    logic [17:0] exp_q[$];
    string       name_q[$];

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word packing:
    // {PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,InstrDone,IllegalOp}
    function automatic logic [17:0] cw(input logic pcen, iord, mr, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, pcs, input logic [2:0] alu,
                                       input logic done, ill);
        return {pcen, iord, mr, mw, irw, rd, m2r, rw, sa, sb, pcs, alu, done, ill};
    endfunction

    function automatic void push(input logic [17:0] w, input string n);
        exp_q.push_back(w);
        name_q.push_back(n);
    endfunction

    // Reference model: the cycle-by-cycle control words of one instruction,
    // written directly from the instruction's step list. Returns its length.
    function automatic int model_push(input logic [5:0] op, input logic z);
        logic legal;
        logic [2:0] ialu;
        legal = (op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h0D ||
                 op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03 ||
                 op == 6'h23 || op == 6'h2B);
        push(cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0), "fetch");
        push(cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,0,!legal), "decode");
        if (!legal) return 2;
        case (op)
            6'h23: begin
                push(cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0), "lw_addr");
                push(cw(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0), "lw_read");
                push(cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,1,0), "lw_wb");
                return 5;
            end
            6'h2B: begin
                push(cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0), "sw_addr");
                push(cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,1,0), "sw_write");
                return 4;
            end
            6'h00: begin
                push(cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0), "r_exec");
                push(cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,1,0), "r_wb");
                return 4;
            end
            6'h08, 6'h0C, 6'h0D: begin
                ialu = (op == 6'h0C) ? 3'b110 : (op == 6'h0D) ? 3'b101 : 3'b100;
                push(cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,ialu,0,0), "i_exec");
                push(cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,1,0), "i_wb");
                return 4;
            end
            6'h04, 6'h05: begin
                push(cw((op == 6'h04) ? z : !z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,1,0), "branch");
                return 3;
            end
            default: begin
                push(cw(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,0), "jump");
                return 3;
            end
        endcase
    endfunction

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH
    task automatic run_instr(input logic [5:0] op, input logic z);
        int n;
        bus.OP = op;
        bus.Zero = z;
        n = model_push(op, z);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare each presented control word against the scoreboard head
    always @(negedge clk) begin
        logic [17:0] got;
        logic [17:0] exp;
        string       nm;
        got = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
               bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
               bus.ALUOp, bus.InstrDone, bus.IllegalOp};
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s: got %05h expected %05h at %0t", nm, got, exp, $time);
            end
        end else if (stim_done && !mon_done) begin
            tests++;
            if (got !== cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0)) begin
                fails++;
                $display("FAIL final_fetch: got %05h expected fetch word", got);
            end
            mon_done <= 1'b1;
        end
    end

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h2B};
        bus.OP = 6'h00;
        bus.Zero = 1'b0;
`ifdef MEM_READY_EN
        bus.MemReady = 1'b1;
`endif
        @(posedge clk);
        #1;
        // Reset held low for three cycles: all outputs zero
        for (int i = 0; i < 3; i++) push('0, "reset_zero");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed cases
        run_instr(6'h00, 1'b0);
        run_instr(6'h23, 1'b0);
        run_instr(6'h2B, 1'b1);
        run_instr(6'h04, 1'b1);
        run_instr(6'h05, 1'b1);
        run_instr(6'h05, 1'b0);
        run_instr(6'h04, 1'b0);
        run_instr(6'h3F, 1'b0);
        run_instr(6'h02, 1'b0);
        run_instr(6'h03, 1'b1);
        run_instr(6'h0C, 1'b0);
        run_instr(6'h0D, 1'b0);

        // Reset asserted during R_EXEC aborts the instruction
        bus.OP = 6'h00;
        push(cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0), "abort_fetch");
        push(cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,0,0), "abort_decode");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push('0, "abort_reset_zero");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(6'h08, 1'b0);

`ifdef MEM_READY_EN
        // SW stalled three cycles in MEM_WR
        bus.OP = 6'h2B;
        push(cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0), "stall_fetch");
        push(cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,0,0), "stall_decode");
        push(cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0), "stall_addr");
        repeat (3) @(posedge clk);
        #1;
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) push(cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0), "stall_wr_wait");
        repeat (3) @(posedge clk);
        #1;
        bus.MemReady = 1'b1;
        push(cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,1,0), "stall_wr_done");
        @(posedge clk);
        #1;
`endif

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 9)];
            run_instr(op, 1'($urandom_range(0, 1)));
        end

        stim_done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
        if (!mon_done) $display("FAIL monitor_drain: queue still holds %0d entries", exp_q.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails + (mon_done ? 0 : 1));
        $finish;
    end

endmodule
